// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares one single-port, synchronous-read instruction RAM between the
// pipeline IF stage (fetch only) and a program loader (word writes).
// At most one access is granted per cycle. When both sides request, the
// side that was not granted last wins. Fetch data returns one cycle after
// the grant. Fetches outside the RAM return NOP_WORD. Loader writes
// outside the RAM are accepted but dropped, and they set a sticky error flag.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   if_req/if_addr      fetch request and byte address
//   if_gnt              fetch accepted this cycle (combinational)
//   if_valid/if_instr   fetch response, one cycle after if_gnt
//   ld_valid/ld_addr/ld_data  loader write request
//   ld_ready            write accepted this cycle (combinational)
//   ld_err              sticky unmapped-write flag
//   ld_count            accepted loader writes, saturating
//   mem_*               single-port RAM macro interface
module imem_arbiter #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [31:0]           if_instr,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  ld_ready,
    output logic                  ld_err,
    output logic [15:0]           ld_count,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    // Last-grant pointer: 1 = loader was granted last, 0 = IF was.
    logic        last_ld_reg;
    logic        valid_reg;
    logic        nop_reg;
    logic [31:0] instr_hold_reg;
    logic        err_reg;
    logic [15:0] count_reg;

    logic        if_mapped;
    logic        ld_mapped;
    logic [31:0] resp_word;

    // The byte-offset bits are never used for word accesses.
    logic        unused_bits;
    assign unused_bits = ^{if_addr[1:0], ld_addr[1:0]};

    assign if_mapped = (if_addr[31:ADDR_WIDTH+2] == '0);
    assign ld_mapped = (ld_addr[31:ADDR_WIDTH+2] == '0);

    // IF wins when it is alone, or when both request and the loader went last.
    always_comb begin
        if_gnt   = 1'b0;
        ld_ready = 1'b0;
        if (!reset) begin
            if (if_req && ld_valid) begin
                if_gnt   = last_ld_reg;
                ld_ready = !last_ld_reg;
            end else begin
                if_gnt   = if_req;
                ld_ready = ld_valid;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = if_addr[ADDR_WIDTH+1:2];
        mem_wdata = ld_data;
        if (ld_ready) begin
            mem_addr = ld_addr[ADDR_WIDTH+1:2];
            mem_en   = ld_mapped;
            mem_we   = ld_mapped;
        end else if (if_gnt) begin
            mem_en   = if_mapped;
        end
    end

    // RAM data only arrives in the response cycle, so the returned word is
    // selected combinationally and captured for holding afterwards.
    assign resp_word = nop_reg ? NOP_WORD : mem_rdata;
    assign if_valid  = valid_reg;
    assign if_instr  = valid_reg ? resp_word : instr_hold_reg;
    assign ld_err    = err_reg;
    assign ld_count  = count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_ld_reg    <= 1'b1;
            valid_reg      <= 1'b0;
            nop_reg        <= 1'b0;
            instr_hold_reg <= 32'h0;
            err_reg        <= 1'b0;
            count_reg      <= 16'h0;
        end else begin
            valid_reg <= if_gnt;
            if (if_gnt) begin
                nop_reg     <= !if_mapped;
                last_ld_reg <= 1'b0;
            end
            if (ld_ready) begin
                last_ld_reg <= 1'b1;
                if (count_reg != 16'hFFFF) begin
                    count_reg <= count_reg + 16'd1;
                end
                if (!ld_mapped) begin
                    err_reg <= 1'b1;
                end
            end
            if (valid_reg) begin
                instr_hold_reg <= resp_word;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a behavioural synchronous RAM.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_err;
    logic [15:0] ld_count;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:255];

    int checks = 0;
    int errors = 0;

    imem_arbiter #(.ADDR_WIDTH(8), .NOP_WORD(32'h00000000)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_err    (ld_err),
        .ld_count  (ld_count),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: word i preloaded with A000_0000 + i.
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA0000000 + i;
        mem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        ld_valid = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
        tick();
        tick();
        // Reset state; requests during reset must not be granted.
        if_req = 1'b1; ld_valid = 1'b1; #1;
        $display("reset state");
        chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_ld_err", {31'h0, ld_err}, 32'h0);
        chk("rst_ld_count", {16'h0, ld_count}, 32'h0);
        chk("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        if_req = 1'b0; ld_valid = 1'b0;
        tick();
        reset = 1'b0;

        // Back-to-back fetches 0, 4, 8.
        if_req = 1'b1; if_addr = 32'h0; #1;
        $display("fetch 0x0");
        chk("f0_gnt", {31'h0, if_gnt}, 32'h1);
        chk("f0_mem_en", {31'h0, mem_en}, 32'h1);
        chk("f0_mem_we", {31'h0, mem_we}, 32'h0);
        chk("f0_mem_addr", {24'h0, mem_addr}, 32'h0);
        tick();
        if_addr = 32'h4; #1;
        $display("fetch 0x4");
        chk("f1_gnt", {31'h0, if_gnt}, 32'h1);
        chk("f1_mem_addr", {24'h0, mem_addr}, 32'h1);
        chk("f0_valid", {31'h0, if_valid}, 32'h1);
        chk("f0_instr", if_instr, 32'hA0000000);
        tick();
        if_addr = 32'h8; #1;
        $display("fetch 0x8");
        chk("f2_gnt", {31'h0, if_gnt}, 32'h1);
        chk("f1_valid", {31'h0, if_valid}, 32'h1);
        chk("f1_instr", if_instr, 32'hA0000001);
        tick();
        if_req = 1'b0; #1;
        chk("f2_valid", {31'h0, if_valid}, 32'h1);
        chk("f2_instr", if_instr, 32'hA0000002);
        tick();
        chk("idle_valid", {31'h0, if_valid}, 32'h0);
        chk("idle_instr_hold", if_instr, 32'hA0000002);

        // Write 0x14 then fetch it.
        ld_valid = 1'b1; ld_addr = 32'h14; ld_data = 32'h23bdfff8; #1;
        $display("write 0x14 <= 23bdfff8");
        chk("w_ready", {31'h0, ld_ready}, 32'h1);
        chk("w_mem_we", {31'h0, mem_we}, 32'h1);
        chk("w_mem_addr", {24'h0, mem_addr}, 32'h5);
        chk("w_mem_wdata", mem_wdata, 32'h23bdfff8);
        tick();
        ld_valid = 1'b0; if_req = 1'b1; if_addr = 32'h14; #1;
        $display("fetch 0x14");
        chk("raw_gnt", {31'h0, if_gnt}, 32'h1);
        chk("w_count", {16'h0, ld_count}, 32'h1);
        tick();
        if_req = 1'b0; #1;
        chk("raw_valid", {31'h0, if_valid}, 32'h1);
        chk("raw_instr", if_instr, 32'h23bdfff8);

        // Reset, then both held 4 cycles: IF, LD, IF, LD.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h20;
        ld_valid = 1'b1; ld_addr = 32'h30; ld_data = 32'h11111111; #1;
        $display("conflict cycle 1");
        chk("c1_if_gnt", {31'h0, if_gnt}, 32'h1);
        chk("c1_ld_ready", {31'h0, ld_ready}, 32'h0);
        tick();
        $display("conflict cycle 2");
        chk("c2_if_gnt", {31'h0, if_gnt}, 32'h0);
        chk("c2_ld_ready", {31'h0, ld_ready}, 32'h1);
        tick();
        $display("conflict cycle 3");
        chk("c3_if_gnt", {31'h0, if_gnt}, 32'h1);
        chk("c3_ld_ready", {31'h0, ld_ready}, 32'h0);
        tick();
        $display("conflict cycle 4");
        chk("c4_if_gnt", {31'h0, if_gnt}, 32'h0);
        chk("c4_ld_ready", {31'h0, ld_ready}, 32'h1);
        tick();
        if_req = 1'b0; ld_valid = 1'b0; #1;
        chk("c_count", {16'h0, ld_count}, 32'h2);

        // Unmapped fetch 0x400 -> nop (RAM output still holds ram[8]).
        if_req = 1'b1; if_addr = 32'h400; #1;
        $display("fetch unmapped 0x400");
        chk("u_gnt", {31'h0, if_gnt}, 32'h1);
        chk("u_mem_en", {31'h0, mem_en}, 32'h0);
        tick();
        if_req = 1'b0; #1;
        chk("u_valid", {31'h0, if_valid}, 32'h1);
        chk("u_instr", if_instr, 32'h0);

        // Unmapped write 0x10000 -> dropped, error set, counted.
        ld_valid = 1'b1; ld_addr = 32'h00010000; ld_data = 32'hDEADBEEF; #1;
        $display("write unmapped 0x10000");
        chk("uw_ready", {31'h0, ld_ready}, 32'h1);
        chk("uw_mem_en", {31'h0, mem_en}, 32'h0);
        chk("uw_mem_we", {31'h0, mem_we}, 32'h0);
        tick();
        ld_valid = 1'b0; #1;
        chk("uw_err", {31'h0, ld_err}, 32'h1);
        chk("uw_count", {16'h0, ld_count}, 32'h3);
        tick();
        chk("uw_err_sticky", {31'h0, ld_err}, 32'h1);

        // Reset the cycle after a fetch grant.
        if_req = 1'b1; if_addr = 32'h0; #1;
        $display("fetch then reset");
        chk("r_gnt", {31'h0, if_gnt}, 32'h1);
        tick();
        if_req = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("r_valid", {31'h0, if_valid}, 32'h0);
        chk("r_count", {16'h0, ld_count}, 32'h0);
        chk("r_err", {31'h0, ld_err}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port, synchronous-read instruction RAM between two requesters:
  - the pipeline IF stage (read-only fetch);
  - a program loader (word writes used to download code before or during run).
- Sits between the IF stage / loader and the RAM macro.
- Grants one access per cycle, with round-robin on conflict.
- Returns fetch data with fixed 1-cycle latency.
- Fetches to unmapped addresses are answered with a nop (32'h00000000).

Parameters:
ADDR_WIDTH, 8, word-address bits of the RAM (depth = 2^ADDR_WIDTH words; byte address bits [ADDR_WIDTH+1:2])
NOP_WORD, 32'h00000000, word returned for unmapped fetches

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
if_req  in  1  IF stage requests a fetch this cycle
if_addr  in  32  fetch byte address; bits [1:0] ignored
if_gnt  out  1  fetch accepted this cycle (combinational)
if_valid  out  1  if_instr valid; registered, one cycle after if_gnt
if_instr  out  32  fetched instruction
ld_valid  in  1  loader presents a write
ld_addr  in  32  write byte address; bits [1:0] ignored
ld_data  in  32  write data
ld_ready  out  1  write accepted this cycle (combinational)
ld_err  out  1  sticky: a loader write hit an unmapped address
ld_count  out  16  number of accepted loader writes, saturating at 16'hFFFF
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM word address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values: if_valid=0, if_instr=0, ld_err=0, ld_count=0, last-grant pointer = LOADER.
- Combinational outputs are 0 during reset: if_gnt, ld_ready, mem_en, mem_we.
- Address mapping:
  - mapped iff addr[31:ADDR_WIDTH+2] == 0;
  - mem_addr = addr[ADDR_WIDTH+1:2].
- Arbitration (per cycle):
  - Only if_req: if_gnt=1.
  - Only ld_valid: ld_ready=1.
  - Both: grant the side that was NOT granted last; the other waits.
  - Last-grant pointer updates only on a cycle with a grant.
- Fetch grant, mapped: mem_en=1, mem_we=0.
- Fetch grant, unmapped: mem_en=0; the returned word is NOP_WORD.
- Fetch response:
  - Registered 1-cycle pipeline: in the cycle after if_gnt, if_valid=1 and if_instr = mem_rdata (or NOP_WORD if unmapped).
  - if_valid=0 in any cycle not following a grant.
  - if_instr holds its last value when if_valid=0.
- Back-to-back fetches sustain 1 per cycle when the loader is idle.
- Loader grant, mapped: mem_en=1, mem_we=1, mem_wdata=ld_data.
- Loader grant, unmapped: no RAM access; ld_ready still 1 (write dropped); ld_err set.
- ld_count increments on every ld_ready, mapped or not; saturates at 16'hFFFF.
- Read-after-write: a write in cycle N is visible to a fetch granted in cycle N+1.
- Simultaneous same-address read and write: cannot occur (one grant per cycle).
- ld_err is cleared only by reset.
- Reset mid-operation: an in-flight fetch response is discarded; if_valid=0 in the cycle after reset.
- Requesters must hold req/addr/data stable until granted.

Test Plan:
- Reset, then if_req=1 with if_addr=0,4,8 on consecutive cycles, loader idle.
  -> if_gnt=1 each cycle; if_valid=1 from cycle 2 with mem_rdata words in order; mem_we=0.
- ld_valid=1 with ld_addr=32'h14, ld_data=32'h23bdfff8, then a fetch of 32'h14 the next cycle.
  -> write then read; if_instr=32'h23bdfff8; ld_count=1.
- Both requesters held for 4 cycles after reset.
  -> grants alternate IF, LD, IF, LD (pointer starts at LOADER); each side granted 2 times.
- Fetch of 32'h0000_0400 (ADDR_WIDTH=8).
  -> mem_en=0; next cycle if_valid=1, if_instr=32'h00000000.
- Write to 32'h0001_0000.
  -> ld_ready=1, mem_en=0, ld_err=1 stays set; ld_count increments.
- Reset asserted the cycle after a fetch grant.
  -> if_valid=0, ld_count=0, ld_err=0 the next cycle.
